// File: rtl/frame_rx_buffer_if.sv
// Port-side bundle for frame_rx_buffer: MAC byte stream in, data/descriptor read side and counters out.
// The design takes the slave modport; the producer/consumer side takes master.
interface frame_rx_buffer_if;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        sfifo_rd;
  logic [7:0]  sfifo_dout;
  logic        ptr_sfifo_rd;
  logic [15:0] ptr_sfifo_dout;
  logic        ptr_sfifo_empty;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  modport master (
    output rx_dv, rx_data, rx_err, sfifo_rd, ptr_sfifo_rd,
    input  sfifo_dout, ptr_sfifo_dout, ptr_sfifo_empty, frame_cnt, drop_cnt
  );

  modport slave (
    input  rx_dv, rx_data, rx_err, sfifo_rd, ptr_sfifo_rd,
    output sfifo_dout, ptr_sfifo_dout, ptr_sfifo_empty, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/frame_rx_buffer.sv
// Store-and-forward receive buffer: bytes land in a circular RAM, good frames commit a length
// descriptor into a pointer FIFO, bad frames are discarded by rewinding the write pointer.
module frame_rx_buffer #(
  parameter int DATA_AW = 12,
  parameter int PTR_AW  = 5,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1518
) (
  input logic clk,
  input logic rstn,
  frame_rx_buffer_if.slave bus
);

  localparam int PW    = DATA_AW + 1;
  localparam int DEPTH = 2 ** DATA_AW;
  localparam int PDEP  = 2 ** PTR_AW;

  localparam logic [PW-1:0]     L_BONE    = {{DATA_AW{1'b0}}, 1'b1};
  localparam logic [PW:0]       L_DEPTH   = {2'b01, {DATA_AW{1'b0}}};
  localparam logic [PW:0]       L_MAXFREE = (PW + 1)'(MAX_LEN);
  localparam logic [PTR_AW:0]   L_PONE    = {{PTR_AW{1'b0}}, 1'b1};
  localparam logic [PTR_AW:0]   L_PDEPTH  = {1'b1, {PTR_AW{1'b0}}};
  localparam logic [10:0]       L_MAX     = 11'(MAX_LEN);
  localparam logic [10:0]       L_MIN     = 11'(MIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_dv_q;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_commit_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [10:0]     r_len;
  logic            r_bad;
  logic [15:0]     r_frame_cnt;
  logic [15:0]     r_drop_cnt;
  logic [7:0]      r_sdout;
  logic [15:0]     r_pdout;
  logic [PTR_AW:0] r_pwr;
  logic [PTR_AW:0] r_prd;
  logic            r_pempty;

  logic [7:0]      r_mem  [DEPTH];
  logic [15:0]     r_pmem [PDEP];

  logic [PW-1:0]   w_used;
  logic [PW:0]     w_free;
  logic            w_pfull;
  logic            w_pempty;
  logic            w_sof;
  logic            w_no_room;
  logic            w_wr_en;
  logic            w_push;
  logic            w_pop;
  logic            w_rd;
  logic [PTR_AW:0] w_pwr_nxt;
  logic [PTR_AW:0] w_prd_nxt;

  // Free space is measured against the consumer's read pointer, so it only grows after reads land.
  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign w_free    = L_DEPTH - {1'b0, w_used};
  assign w_pfull   = ((r_pwr - r_prd) == L_PDEPTH);
  assign w_pempty  = (r_pwr == r_prd);
  assign w_sof     = bus.rx_dv & ~r_dv_q;
  assign w_no_room = (w_free < L_MAXFREE) | w_pfull;

  assign w_wr_en = rstn &
                   (((r_state == ST_IDLE) & w_sof & ~w_no_room) |
                    ((r_state == ST_RECV) & bus.rx_dv & (r_len != L_MAX)));
  assign w_push  = rstn & (r_state == ST_RECV) & ~bus.rx_dv & ~r_bad & (r_len >= L_MIN);
  assign w_pop   = bus.ptr_sfifo_rd & ~w_pempty;
  assign w_rd    = bus.sfifo_rd & (r_rd_ptr != r_commit_ptr);

  assign w_pwr_nxt = w_push ? (r_pwr + L_PONE) : r_pwr;
  assign w_prd_nxt = w_pop  ? (r_prd + L_PONE) : r_prd;

  // Storage arrays: frame bytes and committed descriptors (no reset needed on contents).
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DATA_AW-1:0]] <= bus.rx_data;
    end
    if (w_push) begin
      r_pmem[r_pwr[PTR_AW-1:0]] <= {5'b00000, r_len};
    end
  end

  // Receive FSM: accept, rewind or commit each frame and keep the frame/drop counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_dv_q       <= 1'b1;
      r_wr_ptr     <= {PW{1'b0}};
      r_commit_ptr <= {PW{1'b0}};
      r_len        <= 11'd0;
      r_bad        <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_drop_cnt   <= 16'd0;
    end else begin
      r_dv_q <= bus.rx_dv;
      case (r_state)
        ST_IDLE: begin
          if (w_sof) begin
            if (w_no_room) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
              r_state    <= ST_DROP;
            end else begin
              r_wr_ptr <= r_wr_ptr + L_BONE;
              r_len    <= 11'd1;
              r_bad    <= bus.rx_err;
              r_state  <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (bus.rx_dv) begin
            if (r_len == L_MAX) begin
              r_wr_ptr   <= r_commit_ptr;
              r_drop_cnt <= r_drop_cnt + 16'd1;
              r_state    <= ST_DROP;
            end else begin
              r_wr_ptr <= r_wr_ptr + L_BONE;
              r_len    <= r_len + 11'd1;
              r_bad    <= r_bad | bus.rx_err;
            end
          end else begin
            // First idle cycle after the frame decides its fate.
            if (r_bad || (r_len < L_MIN)) begin
              r_wr_ptr   <= r_commit_ptr;
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
              r_commit_ptr <= r_wr_ptr;
              r_frame_cnt  <= r_frame_cnt + 16'd1;
            end
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!bus.rx_dv) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read side: byte reads stop at the commit pointer, descriptor pops stop at empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_ptr <= {PW{1'b0}};
      r_sdout  <= 8'd0;
      r_pdout  <= 16'd0;
      r_pwr    <= {(PTR_AW + 1){1'b0}};
      r_prd    <= {(PTR_AW + 1){1'b0}};
      r_pempty <= 1'b1;
    end else begin
      if (w_rd) begin
        r_sdout  <= r_mem[r_rd_ptr[DATA_AW-1:0]];
        r_rd_ptr <= r_rd_ptr + L_BONE;
      end
      if (w_pop) begin
        r_pdout <= r_pmem[r_prd[PTR_AW-1:0]];
      end
      r_pwr    <= w_pwr_nxt;
      r_prd    <= w_prd_nxt;
      r_pempty <= (w_pwr_nxt == w_prd_nxt);
    end
  end

  assign bus.sfifo_dout      = r_sdout;
  assign bus.ptr_sfifo_dout  = r_pdout;
  assign bus.ptr_sfifo_empty = r_pempty;
  assign bus.frame_cnt       = r_frame_cnt;
  assign bus.drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_frame_rx_buffer.sv
// Directed bench for frame_rx_buffer: each scenario task drives frames and checks descriptors,
// byte data and counters against hand-computed values.
module tb_frame_rx_buffer;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  frame_rx_buffer_if bus ();

  frame_rx_buffer #(
    .DATA_AW(12),
    .PTR_AW (5),
    .MIN_LEN(60),
    .MAX_LEN(1518)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // byte i of a frame sent with seed s is (s + i) mod 256
  task automatic send_frame(input int len, input int seed, input int err_idx);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      bus.rx_dv   = 1'b1;
      bus.rx_data = 8'((seed + i) & 255);
      bus.rx_err  = (i == err_idx);
    end
    @(posedge clk);
    #1;
    bus.rx_dv  = 1'b0;
    bus.rx_err = 1'b0;
  endtask

  task automatic pop_desc(input string name, input logic [15:0] exp);
    bus.ptr_sfifo_rd = 1'b1;
    @(posedge clk);
    #1;
    bus.ptr_sfifo_rd = 1'b0;
    chk16(name, bus.ptr_sfifo_dout, exp);
  endtask

  task automatic read_frame(input string name, input int len, input int seed);
    logic [7:0] exp;
    bus.sfifo_rd = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      exp = 8'((seed + i) & 255);
      n_tests++;
      if (bus.sfifo_dout !== exp) begin
        n_fail++;
        $display("FAIL %s byte %0d: got %h expected %h", name, i, bus.sfifo_dout, exp);
      end
    end
    bus.sfifo_rd = 1'b0;
  endtask

  task automatic wait_desc(input string name);
    int t;
    t = 0;
    while (bus.ptr_sfifo_empty && (t < 5000)) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_tests++;
    if (bus.ptr_sfifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: descriptor wait timed out, empty=%b expected 0", name, bus.ptr_sfifo_empty);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    chk16("reset_empty", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
    chk16("reset_frame_cnt", bus.frame_cnt, 16'd0);
    chk16("reset_drop_cnt", bus.drop_cnt, 16'd0);
    chk16("reset_sdout", {8'd0, bus.sfifo_dout}, 16'd0);
    chk16("reset_pdout", bus.ptr_sfifo_dout, 16'd0);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_frame();
    send_frame(64, 0, -1);
    chk16("t1_empty_before_commit", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
    idle(1);
    chk16("t1_empty_after_commit", {15'd0, bus.ptr_sfifo_empty}, 16'd0);
    chk16("t1_frame_cnt", bus.frame_cnt, 16'd1);
    pop_desc("t1_desc", 16'h0040);
    read_frame("t1_data", 64, 0);
    // extra read past the commit pointer must not move or change dout
    bus.sfifo_rd = 1'b1;
    idle(1);
    bus.sfifo_rd = 1'b0;
    chk16("t1_read_past_commit", {8'd0, bus.sfifo_dout}, 16'h003F);
    chk16("t1_pempty_after_pop", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
  endtask

  task automatic test_err_frame();
    send_frame(100, 8'h20, 20);
    send_frame(64, 8'h80, -1);
    idle(2);
    chk16("t2_drop_cnt", bus.drop_cnt, 16'd1);
    chk16("t2_frame_cnt", bus.frame_cnt, 16'd2);
    pop_desc("t2_desc", 16'h0040);
    idle(1);
    chk16("t2_single_desc", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
    // pop on empty holds dout
    pop_desc("t2_pop_empty_hold", 16'h0040);
    read_frame("t2_data", 64, 8'h80);
  endtask

  task automatic test_length_bounds();
    send_frame(59, 8'h10, -1);
    send_frame(1519, 8'h30, -1);
    idle(2);
    chk16("t3_runt_oversize_empty", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
    chk16("t3_drop_cnt_a", bus.drop_cnt, 16'd3);
    send_frame(60, 8'h03, -1);
    send_frame(1518, 8'h04, -1);
    idle(2);
    chk16("t3_frame_cnt", bus.frame_cnt, 16'd4);
    chk16("t3_drop_cnt_b", bus.drop_cnt, 16'd3);
    pop_desc("t3_desc_min", 16'h003C);
    read_frame("t3_data_min", 60, 8'h03);
    pop_desc("t3_desc_max", 16'h05EE);
    read_frame("t3_data_max", 1518, 8'h04);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 33; k++) begin
      send_frame(64, k * 7, -1);
    end
    idle(2);
    chk16("t4_drop_cnt_full", bus.drop_cnt, 16'd4);
    chk16("t4_frame_cnt_full", bus.frame_cnt, 16'd36);
    pop_desc("t4_desc_first", 16'h0040);
    read_frame("t4_data_first", 64, 0);
    send_frame(64, 8'hC5, -1);
    idle(2);
    chk16("t4_frame_cnt_after", bus.frame_cnt, 16'd37);
    chk16("t4_drop_cnt_after", bus.drop_cnt, 16'd4);
    for (int k = 1; k < 32; k++) begin
      pop_desc("t4_desc", 16'h0040);
      read_frame("t4_data", 64, k * 7);
    end
    pop_desc("t4_desc_new", 16'h0040);
    read_frame("t4_data_new", 64, 8'hC5);
    idle(1);
    chk16("t4_drained", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
  endtask

  task automatic test_wrap_stream();
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          send_frame(1000, f * 37, -1);
        end
      end
      begin
        for (int f = 0; f < 12; f++) begin
          wait_desc("t5_wait");
          pop_desc("t5_desc", 16'h03E8);
          read_frame("t5_data", 1000, f * 37);
        end
      end
    join
    idle(2);
    chk16("t5_frame_cnt", bus.frame_cnt, 16'd49);
    chk16("t5_drop_cnt", bus.drop_cnt, 16'd4);
    chk16("t5_drained", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      bus.rx_dv   = 1'b1;
      bus.rx_data = 8'(i);
    end
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.rx_data = 8'(i + 100);
    end
    bus.rx_dv = 1'b0;
    idle(3);
    chk16("t6_empty", {15'd0, bus.ptr_sfifo_empty}, 16'd1);
    chk16("t6_frame_cnt", bus.frame_cnt, 16'd0);
    chk16("t6_drop_cnt", bus.drop_cnt, 16'd0);
    send_frame(64, 8'h55, -1);
    idle(2);
    chk16("t6_frame_cnt_after", bus.frame_cnt, 16'd1);
    pop_desc("t6_desc", 16'h0040);
    read_frame("t6_data", 64, 8'h55);
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rstn             = 1'b0;
    bus.rx_dv        = 1'b0;
    bus.rx_data      = 8'd0;
    bus.rx_err       = 1'b0;
    bus.sfifo_rd     = 1'b0;
    bus.ptr_sfifo_rd = 1'b0;
    test_reset();
    test_single_frame();
    test_err_frame();
    test_length_bounds();
    test_back_to_back();
    test_wrap_stream();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
